// File: rtl/raster_addr_gen.sv
// Row-major 2-D raster address generator with line/frame markers and a frame counter.
// Latency: out_valid rises 1 cycle after start; one address per cycle while out_ready is high.
// Backpressure: out_ready=0 freezes every address and marker output; nothing is dropped.
module raster_addr_gen #(
  parameter int NUM_COLS = 1280,
  parameter int NUM_ROWS = 720,
  parameter int COL_W    = 11,
  parameter int ROW_W    = 10,
  parameter int ADDR_W   = 20,
  parameter int FCNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              loop_en,
  input  logic              abort,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [COL_W-1:0]  col_addr,
  output logic [ROW_W-1:0]  row_addr,
  output logic [ADDR_W-1:0] lin_addr,
  output logic              sol,
  output logic              eol,
  output logic              sof,
  output logic              eof,
  output logic              busy,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ADDR_W-1:0]   lin_q, lin_d;
  logic                frame_done_q, frame_done_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic                run;
  logic                xfer;
  logic                at_eol;
  logic                at_last_row;

  assign run         = (state_q == ST_RUN);
  assign xfer        = run && out_ready;
  assign at_eol      = (col_q == COL_LAST);
  assign at_last_row = (row_q == ROW_LAST);

  // Next-state: abort beats everything; the linear address is stepped, never multiplied.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    lin_d        = lin_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    if (abort) begin
      state_d = ST_IDLE;
      col_d   = '0;
      row_d   = '0;
      lin_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
            col_d   = '0;
            row_d   = '0;
            lin_d   = '0;
          end
        end
        ST_RUN: begin
          if (xfer) begin
            if (at_eol && at_last_row) begin
              // Last pixel: wrap to origin; looping keeps RUN so there is no bubble.
              col_d        = '0;
              row_d        = '0;
              lin_d        = '0;
              frame_done_d = 1'b1;
              frame_cnt_d  = frame_cnt_q + FCNT_W'(1);
              state_d      = loop_en ? ST_RUN : ST_IDLE;
            end else if (at_eol) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
              lin_d = lin_q + ADDR_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
              lin_d = lin_q + ADDR_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          col_d   = '0;
          row_d   = '0;
          lin_d   = '0;
        end
      endcase
    end
  end

  // State, counters and the done pulse; reset forces everything to zero immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      lin_q        <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      lin_q        <= lin_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign out_valid  = run;
  assign busy       = run;
  assign col_addr   = col_q;
  assign row_addr   = row_q;
  assign lin_addr   = lin_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

  // Markers decode the registered counters and are qualified by out_valid.
  assign sol = run && (col_q == '0);
  assign eol = run && at_eol;
  assign sof = run && (col_q == '0) && (row_q == '0);
  assign eof = run && at_eol && at_last_row;

endmodule

// File: tb/tb_raster_addr_gen.sv
// Directed bench for raster_addr_gen on a 4x3 frame with a 2-bit frame counter.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected addresses and markers are computed from the pixel index inside the bench.
module tb_raster_addr_gen;

  localparam int NC = 4;
  localparam int NR = 3;
  localparam int CW = 2;
  localparam int RW = 2;
  localparam int AW = 4;
  localparam int FW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          loop_en;
  logic          abort;
  logic          out_ready;
  logic          out_valid;
  logic [CW-1:0] col_addr;
  logic [RW-1:0] row_addr;
  logic [AW-1:0] lin_addr;
  logic          sol, eol, sof, eof;
  logic          busy;
  logic          frame_done;
  logic [FW-1:0] frame_cnt;

  int checks   = 0;
  int failures = 0;

  raster_addr_gen #(
    .NUM_COLS(NC), .NUM_ROWS(NR), .COL_W(CW), .ROW_W(RW), .ADDR_W(AW), .FCNT_W(FW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .loop_en(loop_en), .abort(abort),
    .out_ready(out_ready), .out_valid(out_valid), .col_addr(col_addr),
    .row_addr(row_addr), .lin_addr(lin_addr), .sol(sol), .eol(eol), .sof(sof),
    .eof(eof), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_col"},   32'(col_addr),  32'd0);
    chk({tag, "_row"},   32'(row_addr),  32'd0);
    chk({tag, "_lin"},   32'(lin_addr),  32'd0);
    chk({tag, "_mark"},  32'({sol, eol, sof, eof}), 32'd0);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_done"},  32'(frame_done), 32'd0);
  endtask

  task automatic chk_pix(input string tag, input int i);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_lin"},   32'(lin_addr),  32'(i));
    chk({tag, "_col"},   32'(col_addr),  32'(i % NC));
    chk({tag, "_row"},   32'(row_addr),  32'(i / NC));
    chk({tag, "_sol"},   32'(sol),       32'((i % NC) == 0));
    chk({tag, "_eol"},   32'(eol),       32'((i % NC) == NC - 1));
    chk({tag, "_sof"},   32'(sof),       32'(i == 0));
    chk({tag, "_eof"},   32'(eof),       32'(i == NC * NR - 1));
    chk({tag, "_busy"},  32'(busy),      32'd1);
  endtask

  // Starts at cycle 1 of a frame with out_ready=1, loop_en=0; ends on the frame_done cycle.
  task automatic run_frame(input string tag, input int exp_cnt);
    for (int i = 0; i < NC * NR; i++) begin
      chk_pix(tag, i);
      if (i > 0) chk({tag, "_nodone"}, 32'(frame_done), 32'd0);
      step();
    end
    chk({tag, "_done"},     32'(frame_done), 32'd1);
    chk({tag, "_cnt"},      32'(frame_cnt),  32'(exp_cnt));
    chk({tag, "_endvalid"}, 32'(out_valid),  32'd0);
  endtask

  initial begin
    int exp_lin;
    int k;

    reset = 1'b1; start = 1'b0; loop_en = 1'b0; abort = 1'b0; out_ready = 1'b1;
    #1;
    chk_zero("rst");
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    step();
    reset = 1'b0;
    step();
    chk_zero("idle");

    // Single frame with a one-cycle start pulse.
    start = 1'b1;
    step();
    start = 1'b0;
    run_frame("t1", 1);
    step();
    chk("t1_pulse", 32'(frame_done), 32'd0);

    // Backpressure: ready pattern 1,0,0 repeating; addresses must hold across stalls.
    start = 1'b1;
    step();
    start = 1'b0;
    exp_lin = 0;
    k = 0;
    while (exp_lin < NC * NR && k < 100) begin
      out_ready = ((k % 3) == 0);
      chk("t2_valid", 32'(out_valid), 32'd1);
      chk("t2_lin",   32'(lin_addr),  32'(exp_lin));
      chk("t2_col",   32'(col_addr),  32'(exp_lin % NC));
      chk("t2_row",   32'(row_addr),  32'(exp_lin / NC));
      if (out_ready) exp_lin++;
      k++;
      step();
    end
    out_ready = 1'b1;
    chk("t2_xfers", 32'(exp_lin),    32'(NC * NR));
    chk("t2_done",  32'(frame_done), 32'd1);
    chk("t2_cnt",   32'(frame_cnt),  32'd2);
    chk("t2_valid_end", 32'(out_valid), 32'd0);

    // Clear the counter so the looping frames count 1, 2, 3.
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t3_cnt0", 32'(frame_cnt), 32'd0);

    // Continuous frames: no bubble between frames.
    loop_en = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int f = 1; f <= 3; f++) begin
      for (int i = 0; i < NC * NR; i++) begin
        chk_pix("t3", i);
        if (i == 0) begin
          chk("t3_done", 32'(frame_done), 32'(f > 1));
          chk("t3_cnt",  32'(frame_cnt),  32'(f - 1));
        end else begin
          chk("t3_nodone", 32'(frame_done), 32'd0);
        end
        step();
      end
    end
    chk("t3_done_last", 32'(frame_done), 32'd1);
    chk("t3_cnt_last",  32'(frame_cnt),  32'd3);
    chk_pix("t3_wrap", 0);

    // Abort at row 1, col 2 with a transfer pending.
    for (int i = 0; i < 6; i++) step();
    chk("t4_col", 32'(col_addr), 32'd2);
    chk("t4_row", 32'(row_addr), 32'd1);
    loop_en = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_zero("t4_abort");
    chk("t4_cnt", 32'(frame_cnt), 32'd3);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_pix("t4_restart", 0);

    // Asynchronous reset mid-frame, between clock edges.
    for (int i = 0; i < 3; i++) step();
    chk("t5_pre_lin", 32'(lin_addr), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("t5_async");
    chk("t5_cnt", 32'(frame_cnt), 32'd0);
    step();
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    run_frame("t5", 1);

    // start held high: ignored in RUN, taken again on each frame_done cycle; counter wraps.
    start = 1'b1;
    step();
    run_frame("t6a", 2);
    step();
    run_frame("t6b", 3);
    step();
    run_frame("t6c", 0);
    start = 1'b0;
    step();
    chk("t6_idle_valid", 32'(out_valid),  32'd0);
    chk("t6_idle_done",  32'(frame_done), 32'd0);
    chk("t6_idle_cnt",   32'(frame_cnt),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/raster_addr_gen.md
Name: raster_addr_gen

Overview:
- Parametrised 2-D raster address generator: walks a NUM_COLS x NUM_ROWS frame in row-major order.
- Presents column, row and linear addresses through a valid/ready stream interface, with line and frame markers.
- Supports single-shot and continuous (looping) frames, abort, and a frame counter.
- Sits between the frame-timing control and the pixel-buffer read/write address ports.

Parameters:
- NUM_COLS, 1280, pixels per line (>=2)
- NUM_ROWS, 720, lines per frame (>=2)
- COL_W, 11, column address width; must satisfy 2^COL_W >= NUM_COLS
- ROW_W, 10, row address width; must satisfy 2^ROW_W >= NUM_ROWS
- ADDR_W, 20, linear address width; must satisfy 2^ADDR_W >= NUM_COLS*NUM_ROWS
- FCNT_W, 8, frame counter width

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- start  input  1  begin frame generation; sampled in IDLE only
- loop_en  input  1  1 = restart at (0,0) after last pixel; sampled on the last-pixel transfer
- abort  input  1  synchronous stop; returns to IDLE
- out_ready  input  1  downstream accepts the current address
- out_valid  output  1  address outputs valid
- col_addr  output  COL_W  current column
- row_addr  output  ROW_W  current row
- lin_addr  output  ADDR_W  row_addr*NUM_COLS + col_addr
- sol  output  1  start of line (col_addr==0), gated by out_valid
- eol  output  1  end of line (col_addr==NUM_COLS-1), gated by out_valid
- sof  output  1  first pixel of frame, gated by out_valid
- eof  output  1  last pixel of frame, gated by out_valid
- busy  output  1  state is RUN
- frame_done  output  1  one-cycle pulse after a completed frame
- frame_cnt  output  FCNT_W  completed frames, wraps modulo 2^FCNT_W

Behaviour:
- Reset (async assert, clk-synchronous release): state IDLE. Every output is 0: out_valid, all addresses, all markers, busy, frame_done, frame_cnt.
- States: IDLE and RUN.
- IDLE:
  - out_valid=0.
  - start=1 -> RUN on the next edge, with col/row/lin addresses set to 0.
  - out_valid rises 1 cycle after start (latency 1).
- RUN:
  - out_valid=1.
  - A transfer occurs when out_valid & out_ready.
  - While out_ready=0, all address and marker outputs hold stable.
- Advance on each transfer:
  - If col_addr < NUM_COLS-1: col_addr+1 and lin_addr+1.
  - Else: col_addr=0, row_addr+1, lin_addr+1.
  - lin_addr is maintained incrementally; no multiplier.
- Last-pixel transfer (row NUM_ROWS-1, col NUM_COLS-1):
  - frame_done pulses high on the following cycle.
  - frame_cnt increments at the same edge as the pulse.
  - If loop_en=1: all addresses return to 0, stay in RUN, out_valid stays 1. No bubble.
  - If loop_en=0: go to IDLE, out_valid=0 next cycle. Addresses return to 0.
- start while in RUN: ignored.
- start on the same cycle frame_done is asserted (now IDLE): accepted normally.
- abort=1 in any state:
  - Next cycle state is IDLE, out_valid=0, addresses 0.
  - No frame_done; frame_cnt unchanged.
  - abort has priority over a simultaneous transfer and over start.
- Address counters never exceed NUM_COLS-1 / NUM_ROWS-1.
- Markers are combinational from the registered counters, ANDed with out_valid.
- Reset mid-frame: immediate return to reset values; no frame_done.

Test Plan:
1. NUM_COLS=4, NUM_ROWS=3, out_ready=1, loop_en=0, start pulse at cycle 0:
   - out_valid=1 for cycles 1..12.
   - lin_addr runs 0..11; eol at lin 3, 7, 11; eof only at lin 11.
   - frame_done=1 at cycle 13, frame_cnt=1; out_valid=0 at cycle 13.
2. Backpressure, same parameters: out_ready toggles 1,0,0,1,...
   - Outputs hold across stalled cycles.
   - Exactly 12 transfers with lin_addr 0..11 in order; no skips or duplicates.
3. loop_en=1, out_ready=1:
   - After lin_addr=11, next cycle shows lin_addr=0, sof=1, out_valid=1 continuously.
   - frame_done pulses once per 12 transfers; frame_cnt counts 1, 2, 3.
4. abort asserted while at row 1, col 2 with out_ready=1:
   - Next cycle out_valid=0, addresses 0, frame_done=0, frame_cnt unchanged.
   - A subsequent start restarts at (0,0).
5. Reset asserted mid-frame asynchronously (between edges):
   - All outputs 0 immediately.
   - start after release gives a full frame 0..11.
6. start held high during RUN and on the frame_done cycle:
   - No restart during RUN.
   - The new frame begins one cycle after frame_done; frame_cnt wrap checked with FCNT_W=2 (3->0).
